// File: rtl/tilelink_nto1_arbiter_if.sv
// A and D channel bundle shared by N TileLink-UL masters, the arbiter and one slave.
// Master buses are flattened, master i at slice i.
interface tilelink_nto1_arbiter_if #(
  parameter int MASTERS = 2,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int SW      = 4,
  parameter int ZW      = 4
);
  localparam int M   = MASTERS;
  localparam int IW  = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int SSW = SW + IW;
  localparam int BW  = DW / 8;

  logic [3*M-1:0]  m_a_opcode;
  logic [3*M-1:0]  m_a_param;
  logic [ZW*M-1:0] m_a_size;
  logic [SW*M-1:0] m_a_source;
  logic [AW*M-1:0] m_a_address;
  logic [BW*M-1:0] m_a_mask;
  logic [DW*M-1:0] m_a_data;
  logic [M-1:0]    m_a_corrupt;
  logic [M-1:0]    m_a_valid;
  logic [M-1:0]    m_a_ready;

  logic [3*M-1:0]  m_d_opcode;
  logic [2*M-1:0]  m_d_param;
  logic [ZW*M-1:0] m_d_size;
  logic [SW*M-1:0] m_d_source;
  logic [M-1:0]    m_d_denied;
  logic [M-1:0]    m_d_corrupt;
  logic [DW*M-1:0] m_d_data;
  logic [M-1:0]    m_d_valid;
  logic [M-1:0]    m_d_ready;

  logic [2:0]      s_a_opcode;
  logic [2:0]      s_a_param;
  logic [ZW-1:0]   s_a_size;
  logic [SSW-1:0]  s_a_source;
  logic [AW-1:0]   s_a_address;
  logic [BW-1:0]   s_a_mask;
  logic [DW-1:0]   s_a_data;
  logic            s_a_corrupt;
  logic            s_a_valid;
  logic            s_a_ready;

  logic [2:0]      s_d_opcode;
  logic [1:0]      s_d_param;
  logic [ZW-1:0]   s_d_size;
  logic [SSW-1:0]  s_d_source;
  logic            s_d_denied;
  logic            s_d_corrupt;
  logic [DW-1:0]   s_d_data;
  logic            s_d_valid;
  logic            s_d_ready;

  modport slave (
    input  m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address,
    input  m_a_mask, m_a_data, m_a_corrupt, m_a_valid,
    output m_a_ready,
    output m_d_opcode, m_d_param, m_d_size, m_d_source, m_d_denied,
    output m_d_corrupt, m_d_data, m_d_valid,
    input  m_d_ready,
    output s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address,
    output s_a_mask, s_a_data, s_a_corrupt, s_a_valid,
    input  s_a_ready,
    input  s_d_opcode, s_d_param, s_d_size, s_d_source, s_d_denied,
    input  s_d_corrupt, s_d_data, s_d_valid,
    output s_d_ready
  );

  modport master (
    output m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address,
    output m_a_mask, m_a_data, m_a_corrupt, m_a_valid,
    input  m_a_ready,
    input  m_d_opcode, m_d_param, m_d_size, m_d_source, m_d_denied,
    input  m_d_corrupt, m_d_data, m_d_valid,
    output m_d_ready,
    input  s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address,
    input  s_a_mask, s_a_data, s_a_corrupt, s_a_valid,
    output s_a_ready,
    output s_d_opcode, s_d_param, s_d_size, s_d_source, s_d_denied,
    output s_d_corrupt, s_d_data, s_d_valid,
    input  s_d_ready
  );
endinterface

// File: rtl/tilelink_nto1_arbiter.sv
// N-to-1 TileLink-UL arbiter: round-robin A channel with burst/stall lock,
// D channel routed back by source-ID prefix.
module tilelink_nto1_arbiter #(
  parameter int MASTERS = 2,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int SW      = 4,
  parameter int ZW      = 4
) (
  input  logic                    tilelink_clock_i,
  input  logic                    tilelink_reset_ni,
  tilelink_nto1_arbiter_if.slave  bus
);
  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int BW = DW / 8;
  localparam int LB = $clog2(BW);
  localparam logic [IW:0] M_N = (IW+1)'(MASTERS);

  typedef enum logic [1:0] {IDLE, HOLD, BURST} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [11:0]          cnt_q, cnt_d;
  logic [IW-1:0]        scan, sel, off, d_idx;
  logic [IW:0]          sum;
  logic [2*MASTERS-1:0] rot;
  logic [3:0]           sz_c;
  logic [12:0]          beats;
  logic                 rst_n, any_v, fire;

  assign rst_n = tilelink_reset_ni;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
    return (({1'b0, p} + 1'b1) == M_N) ? '0 : p + 1'b1;
  endfunction

  // Rotate valids so bit 0 is the rr_ptr master; the lowest set bit wins.
  always_comb begin
    rot = {bus.m_a_valid, bus.m_a_valid} >> rr_q;
    off = '0;
    for (int k = MASTERS - 1; k >= 0; k--)
      if (rot[k]) off = IW'(k);
    sum  = {1'b0, rr_q} + {1'b0, off};
    scan = (sum >= M_N) ? IW'(sum - M_N) : sum[IW-1:0];
  end

  assign sel   = (state_q == IDLE) ? scan : grant_q;
  assign any_v = |bus.m_a_valid;

  always_comb begin
    bus.s_a_opcode  = bus.m_a_opcode[2:0];
    bus.s_a_param   = bus.m_a_param[2:0];
    bus.s_a_size    = bus.m_a_size[ZW-1:0];
    bus.s_a_source  = {sel, bus.m_a_source[SW-1:0]};
    bus.s_a_address = bus.m_a_address[AW-1:0];
    bus.s_a_mask    = bus.m_a_mask[BW-1:0];
    bus.s_a_data    = bus.m_a_data[DW-1:0];
    bus.s_a_corrupt = bus.m_a_corrupt[0];
    bus.s_a_valid   = 1'b0;
    bus.m_a_ready   = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (sel == IW'(i)) begin
        bus.s_a_opcode  = bus.m_a_opcode[i*3 +: 3];
        bus.s_a_param   = bus.m_a_param[i*3 +: 3];
        bus.s_a_size    = bus.m_a_size[i*ZW +: ZW];
        bus.s_a_source  = {sel, bus.m_a_source[i*SW +: SW]};
        bus.s_a_address = bus.m_a_address[i*AW +: AW];
        bus.s_a_mask    = bus.m_a_mask[i*BW +: BW];
        bus.s_a_data    = bus.m_a_data[i*DW +: DW];
        bus.s_a_corrupt = bus.m_a_corrupt[i];
        bus.s_a_valid   = rst_n & bus.m_a_valid[i];
        bus.m_a_ready[i] = rst_n & bus.s_a_ready & any_v;
      end
    end
  end

  assign fire = bus.s_a_valid & bus.s_a_ready;

  // Only the data-carrying opcodes (0..3) span several beats.
  always_comb begin
    sz_c  = (bus.s_a_size > ZW'(12)) ? 4'd12 : 4'(bus.s_a_size);
    beats = 13'd1;
    if (bus.s_a_opcode <= 3'd3 && sz_c > 4'(LB))
      beats = 13'd1 << (sz_c - 4'(LB));
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, HOLD: begin
        if (fire) begin
          rr_d    = nxt(sel);
          grant_d = sel;
          if (beats > 13'd1) begin
            state_d = BURST;
            cnt_d   = 12'(beats - 13'd1);
          end else begin
            state_d = IDLE;
          end
        end else if (bus.s_a_valid) begin
          state_d = HOLD;
          grant_d = sel;
        end
      end
      BURST: begin
        if (fire) begin
          cnt_d = cnt_q - 12'd1;
          if (cnt_q == 12'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
    if (!tilelink_reset_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d_idx = bus.s_d_source[SW+IW-1:SW];

  // Prefixes with no master behind them are sunk so the slave never stalls.
  always_comb begin
    bus.m_d_valid = '0;
    bus.s_d_ready = rst_n;
    for (int i = 0; i < MASTERS; i++) begin
      if (d_idx == IW'(i)) begin
        bus.m_d_valid[i] = rst_n & bus.s_d_valid;
        bus.s_d_ready    = rst_n & bus.m_d_ready[i];
      end
    end
  end

  assign bus.m_d_opcode  = {MASTERS{bus.s_d_opcode}};
  assign bus.m_d_param   = {MASTERS{bus.s_d_param}};
  assign bus.m_d_size    = {MASTERS{bus.s_d_size}};
  assign bus.m_d_source  = {MASTERS{bus.s_d_source[SW-1:0]}};
  assign bus.m_d_denied  = {MASTERS{bus.s_d_denied}};
  assign bus.m_d_corrupt = {MASTERS{bus.s_d_corrupt}};
  assign bus.m_d_data    = {MASTERS{bus.s_d_data}};
endmodule
